// File: rtl/bf16_addsub_pipe.sv
// bf16_addsub_pipe: three-stage BF16 add/subtract with valid/ready flow control.
// Define BF16_ADDSUB_RNE_EN for round-to-nearest-even; otherwise results are truncated.
module bf16_addsub_pipe #(
  parameter int          PIPE_DEPTH = 3,
  parameter logic [15:0] CANON_NAN  = 16'h7FC0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  input  logic        in_op,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_sum,
  output logic [2:0]  out_flags
);

  if (PIPE_DEPTH != 3) begin : g_bad_depth
    $error("bf16_addsub_pipe: PIPE_DEPTH must be 3");
  end

  function automatic logic [3:0] lzc11(input logic [10:0] v);
    lzc11 = 4'd11;
    for (int i = 0; i < 11; i++) begin
      if (v[i]) lzc11 = 4'(10 - i);
    end
  endfunction

  logic        advance;
  logic        s1_valid_q, s1_valid_d, s1_sign_q, s1_sign_d, s1_sub_q, s1_sub_d;
  logic        s1_nan_q, s1_nan_d, s1_inf_q, s1_inf_d;
  logic [7:0]  s1_exp_q, s1_exp_d;
  logic [10:0] s1_big_q, s1_big_d, s1_small_q, s1_small_d;
  logic        s2_valid_q, s2_valid_d, s2_sign_q, s2_sign_d, s2_sub_q, s2_sub_d;
  logic        s2_nan_q, s2_nan_d, s2_inf_q, s2_inf_d;
  logic [7:0]  s2_exp_q, s2_exp_d;
  logic [11:0] s2_sum_q, s2_sum_d;
  logic        out_valid_q, out_valid_d;
  logic [15:0] out_sum_q, out_sum_d;
  logic [2:0]  out_flags_q, out_flags_d;

  logic        eff_sign_b, nan_a, nan_b, inf_a, inf_b, swap;
  logic [14:0] mag_a, mag_b, big_mag, small_mag;
  logic [7:0]  m_big, m_small, diff;
  logic [21:0] ext;
  logic [3:0]  lz;
  logic [10:0] norm;
  logic signed [9:0] exp_n, exp_r;
  logic [6:0]  mant;
  logic        inexact;
`ifdef BF16_ADDSUB_RNE_EN
  logic        inc;
  logic [8:0]  rnd;
`endif

  assign advance   = !out_valid_q || out_ready;
  assign in_ready  = advance;
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_flags = out_flags_q;

  // Stage 1: unpack, flush subnormals, order by magnitude, align the smaller operand.
  always_comb begin
    eff_sign_b = in_b[15] ^ in_op;
    nan_a      = (in_a[14:7] == 8'hFF) && (in_a[6:0] != 7'd0);
    nan_b      = (in_b[14:7] == 8'hFF) && (in_b[6:0] != 7'd0);
    inf_a      = (in_a[14:7] == 8'hFF) && (in_a[6:0] == 7'd0);
    inf_b      = (in_b[14:7] == 8'hFF) && (in_b[6:0] == 7'd0);
    mag_a      = (in_a[14:7] == 8'd0) ? 15'd0 : in_a[14:0];
    mag_b      = (in_b[14:7] == 8'd0) ? 15'd0 : in_b[14:0];
    swap       = (mag_b > mag_a);
    big_mag    = swap ? mag_b : mag_a;
    small_mag  = swap ? mag_a : mag_b;
    m_big      = (big_mag[14:7] == 8'd0) ? 8'd0 : {1'b1, big_mag[6:0]};
    m_small    = (small_mag[14:7] == 8'd0) ? 8'd0 : {1'b1, small_mag[6:0]};
    diff       = big_mag[14:7] - small_mag[14:7];
    ext        = {m_small, 14'd0} >> diff;
    if (diff >= 8'd11) begin
      s1_small_d = {10'd0, |m_small};
    end else begin
      s1_small_d = ext[21:11] | {10'd0, |ext[10:0]};
    end
    s1_big_d   = {m_big, 3'b000};
    s1_exp_d   = big_mag[14:7];
    s1_sub_d   = in_a[15] ^ eff_sign_b;
    s1_nan_d   = nan_a | nan_b | (inf_a & inf_b & s1_sub_d);
    s1_inf_d   = inf_a | inf_b;
    s1_valid_d = in_valid;
    if (inf_a) begin
      s1_sign_d = in_a[15];
    end else if (inf_b || swap) begin
      s1_sign_d = eff_sign_b;
    end else begin
      s1_sign_d = in_a[15];
    end
  end

  // Stage 2: magnitude add or subtract (the larger operand is always first).
  always_comb begin
    s2_valid_d = s1_valid_q;
    s2_sign_d  = s1_sign_q;
    s2_sub_d   = s1_sub_q;
    s2_nan_d   = s1_nan_q;
    s2_inf_d   = s1_inf_q;
    s2_exp_d   = s1_exp_q;
    if (s1_sub_q) begin
      s2_sum_d = {1'b0, s1_big_q} - {1'b0, s1_small_q};
    end else begin
      s2_sum_d = {1'b0, s1_big_q} + {1'b0, s1_small_q};
    end
  end

  // Stage 3: normalize, round, detect range limits and pack the result.
  always_comb begin
    lz = lzc11(s2_sum_q[10:0]);
    if (s2_sum_q[11]) begin
      norm  = {s2_sum_q[11:2], s2_sum_q[1] | s2_sum_q[0]};
      exp_n = $signed({2'b00, s2_exp_q}) + 10'sd1;
    end else begin
      norm  = s2_sum_q[10:0] << lz;
      exp_n = $signed({2'b00, s2_exp_q}) - $signed({6'd0, lz});
    end
    inexact = |norm[2:0];
`ifdef BF16_ADDSUB_RNE_EN
    inc = norm[2] & (norm[3] | norm[1] | norm[0]);
    rnd = {1'b0, norm[10:3]} + {8'd0, inc};
    if (rnd[8]) begin
      mant  = rnd[7:1];
      exp_r = exp_n + 10'sd1;
    end else begin
      mant  = rnd[6:0];
      exp_r = exp_n;
    end
`else
    mant  = norm[9:3];
    exp_r = exp_n;
`endif
    out_valid_d = s2_valid_q;
    out_sum_d   = 16'h0000;
    out_flags_d = 3'b000;
    // A clear leading bit after normalization means the sum was exactly zero.
    if (s2_nan_q) begin
      out_sum_d   = CANON_NAN;
      out_flags_d = 3'b100;
    end else if (s2_inf_q) begin
      out_sum_d   = {s2_sign_q, 8'hFF, 7'd0};
    end else if (!norm[10]) begin
      out_sum_d   = {s2_sign_q & ~s2_sub_q, 15'd0};
    end else if (exp_n <= 10'sd0) begin
      out_sum_d   = {s2_sign_q, 15'd0};
      out_flags_d = 3'b001;
    end else if (exp_r >= 10'sd255) begin
      out_sum_d   = {s2_sign_q, 8'hFF, 7'd0};
      out_flags_d = {1'b0, 1'b1, inexact};
    end else begin
      out_sum_d   = {s2_sign_q, exp_r[7:0], mant};
      out_flags_d = {2'b00, inexact};
    end
  end

  // Pipeline registers: all stages advance together or hold together.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;  s1_sign_q <= 1'b0;  s1_sub_q <= 1'b0;
      s1_nan_q    <= 1'b0;  s1_inf_q  <= 1'b0;  s1_exp_q <= 8'd0;
      s1_big_q    <= 11'd0; s1_small_q <= 11'd0;
      s2_valid_q  <= 1'b0;  s2_sign_q <= 1'b0;  s2_sub_q <= 1'b0;
      s2_nan_q    <= 1'b0;  s2_inf_q  <= 1'b0;  s2_exp_q <= 8'd0;
      s2_sum_q    <= 12'd0;
      out_valid_q <= 1'b0;  out_sum_q <= 16'h0000; out_flags_q <= 3'b000;
    end else if (advance) begin
      s1_valid_q  <= s1_valid_d; s1_sign_q <= s1_sign_d; s1_sub_q <= s1_sub_d;
      s1_nan_q    <= s1_nan_d;   s1_inf_q  <= s1_inf_d;  s1_exp_q <= s1_exp_d;
      s1_big_q    <= s1_big_d;   s1_small_q <= s1_small_d;
      s2_valid_q  <= s2_valid_d; s2_sign_q <= s2_sign_d; s2_sub_q <= s2_sub_d;
      s2_nan_q    <= s2_nan_d;   s2_inf_q  <= s2_inf_d;  s2_exp_q <= s2_exp_d;
      s2_sum_q    <= s2_sum_d;
      out_valid_q <= out_valid_d; out_sum_q <= out_sum_d; out_flags_q <= out_flags_d;
    end
  end

endmodule

// File: doc/bf16_addsub_pipe.md
Name: bf16_addsub_pipe

Overview:
- Pipelined BF16 add/subtract unit with valid/ready handshakes on both sides. Computes a+b or a−b.
- Sits in the aggregation datapath of the GNN accelerator, where messages are combined and residuals subtracted.
- Replaces the combinational adder wherever timing closure requires registered stages.
- Three-stage pipeline; sustains one result per clock when not back-pressured.

Parameters:
- PIPE_DEPTH, 3, number of register stages. Fixed at 3; any other value is rejected with an elaboration error.
- CANON_NAN, 16'h7FC0, value emitted for any NaN result.

Ports:
- clk  input  1  clock. All logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  unit can accept an operand pair this cycle.
- in_a  input  16  BF16 operand A.
- in_b  input  16  BF16 operand B.
- in_op  input  1  0 = A+B, 1 = A−B.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_sum  output  16  BF16 result.
- out_flags  output  3  {nan, overflow, inexact}, aligned with out_sum.

Behaviour:
- Reset (sync, active-high): all stage valids = 0, out_valid = 0, out_sum = 16'h0000, out_flags = 3'b000. Reset asserted mid-operation discards all in-flight items; no partial output.
- Handshake:
  - Transfer occurs on any cycle with valid && ready high.
  - Global advance = !out_valid || out_ready; in_ready = advance.
  - While stalled (out_valid && !out_ready), every stage holds, and out_sum/out_flags stay stable.
  - Pipeline bubbles are not compressed during a stall.
- Latency: an operand accepted in cycle N appears with out_valid in cycle N+3 when no stall occurs. Throughput is 1 per cycle.
- Stage 1 (unpack/align):
  - If in_op = 1, invert the sign of B.
  - Exponent 0 means zero: subnormals flush to zero with their sign kept.
  - Restore the hidden bit.
  - Swap operands so that |A| ≥ |B|, comparing exponent then mantissa.
  - Right-shift the smaller mantissa by the exponent difference into an 11-bit field (8 mantissa bits + guard, round, sticky).
  - A shift of 11 or more leaves sticky only.
- Stage 2 (add):
  - Same effective sign: 12-bit magnitude add.
  - Different effective sign: subtract smaller from larger.
  - Result sign = sign of the larger operand.
- Stage 3 (normalize/round/pack):
  - Carry out: shift right 1 and increment exponent.
  - Otherwise: leading-zero count, then left shift and decrement exponent.
  - Round to nearest, ties to even, using guard/round/sticky (see Optional Feature).
  - A mantissa carry from rounding renormalizes.
  - Exponent ≥ 255 → signed infinity, overflow flag set.
  - Exponent ≤ 0 → signed zero (flush to zero), inexact flag set.
  - inexact = any discarded bit was nonzero.
- Special cases:
  - Either input NaN → CANON_NAN with nan flag.
  - Inf − Inf (effective) → CANON_NAN with nan flag.
  - Inf ± finite → that Inf.
  - Exact cancellation → +0 (16'h0000).
  - (−0) + (−0) → 16'h8000.
- in_valid low: a bubble propagates, and out_valid stays low for that slot.
- Inputs are not required to be stable once accepted.

Optional Feature:
- Macro: BF16_ADDSUB_RNE_EN.
- Defined: round to nearest, ties to even, as specified above.
- Undefined:
  - Truncation (round toward zero); guard/round/sticky are used only to set inexact.
  - No rounding incrementer and no renormalization after rounding.
  - Latency unchanged.

Test Plan:
- 16'h3FC0 + 16'h4020, op=0, out_ready=1 → 16'h4080 exactly 3 cycles after acceptance, flags 000.
- Subtraction and cancellation:
  - 16'h4020 − 16'h3FC0, op=1 → 16'h3F80.
  - 16'h3F80 − 16'h3F80 → 16'h0000.
  - 16'h8000 + 16'h8000 → 16'h8000.
- Rounding: 16'h3F81 + 16'h3B80 (exact tie) → 16'h3F82 with RNE, 16'h3F81 without; inexact = 1 in both builds.
- Overflow/special:
  - 16'h7F7F + 16'h7F7F → 16'h7F80, overflow = 1.
  - 16'h7F80 − 16'h7F80 → 16'h7FC0, nan = 1.
  - 16'h7FC1 + 16'h3F80 → 16'h7FC0.
- Back-pressure:
  - Stimulus: stream 6 back-to-back pairs (1.0 + k·1.0, k = 0..5); hold out_ready low for 5 cycles after the first out_valid.
  - Required response: out_sum holds 16'h3F80 stable and in_ready = 0 during the stall.
  - On release, results 1.0, 2.0, 3.0, 4.0, 5.0, 6.0 appear in order; none are lost or duplicated.
- Reset mid-stream: assert rst for 1 cycle with 3 items in flight → next cycle out_valid = 0 and out_sum = 16'h0000; none of the 3 in-flight items is ever output.
